attn_spike_feeder: RTL and testbench

- Transmit side of the attention PE spike interface.
- Reads packed Query and Key spike chunks from the two on-chip spike buffers and streams every (query row, key row) pair into the attention PE as `o_Spikesdata_valid` / `o_SpikesdataQuery` / `o_SpikesdataKey` beats.
- Each beat carries one chunk of 2*SYSTOLIC_UNIT_NUM channels × TIME_STEPS spikes.
- Tags each beat with pair and row boundaries so the downstream accumulator can close each QK^T score.

---
 rtl/attn_spike_feeder_if.sv | 39 +++
 rtl/attn_spike_feeder.sv | 165 ++++++++++++++++
 tb/tb_attn_spike_feeder.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/attn_spike_feeder_if.sv
// Spike feeder bus: start/ready control, Q/K buffer read ports and the PE beat stream.
`timescale 1ns/1ps
interface attn_spike_feeder_if #(
    parameter int unsigned DW = 64,
    parameter int unsigned AW = 8,
    parameter int unsigned IW = 6
);
    logic          i_start;
    logic          i_ready;
    logic          o_q_rd_en;
    logic [AW-1:0] o_q_rd_addr;
    logic [DW-1:0] i_q_rd_data;
    logic          o_k_rd_en;
    logic [AW-1:0] o_k_rd_addr;
    logic [DW-1:0] i_k_rd_data;
    logic          o_Spikesdata_valid;
    logic [DW-1:0] o_SpikesdataQuery;
    logic [DW-1:0] o_SpikesdataKey;
    logic          o_pair_last;
    logic          o_row_last;
    logic [IW-1:0] o_q_idx;
    logic [IW-1:0] o_k_idx;
    logic          o_busy;
    logic          o_done;

    modport master (
        input  i_start, i_ready, i_q_rd_data, i_k_rd_data,
        output o_q_rd_en, o_q_rd_addr, o_k_rd_en, o_k_rd_addr,
               o_Spikesdata_valid, o_SpikesdataQuery, o_SpikesdataKey,
               o_pair_last, o_row_last, o_q_idx, o_k_idx, o_busy, o_done
    );

    modport slave (
        output i_start, i_ready, i_q_rd_data, i_k_rd_data,
        input  o_q_rd_en, o_q_rd_addr, o_k_rd_en, o_k_rd_addr,
               o_Spikesdata_valid, o_SpikesdataQuery, o_SpikesdataKey,
               o_pair_last, o_row_last, o_q_idx, o_k_idx, o_busy, o_done
    );
endinterface

// File: rtl/attn_spike_feeder.sv
// Streams every (query row, key row) chunk pair from the Q/K spike buffers into the attention PE.
// Optional ATTN_FEEDER_CAUSAL_EN restricts the key loop to k_idx <= q_idx.
`timescale 1ns/1ps
module attn_spike_feeder #(
    parameter int unsigned SYSTOLIC_UNIT_NUM = 8,
    parameter int unsigned TIME_STEPS        = 4,
    parameter int unsigned TOKENS            = 64,
    parameter int unsigned HEAD_DIM          = 64
) (
    input  logic                 s_clk,
    input  logic                 s_rst,
    attn_spike_feeder_if.master  bus
);
    localparam int unsigned DW     = 2 * SYSTOLIC_UNIT_NUM * TIME_STEPS;
    localparam int unsigned CHUNKS = HEAD_DIM / (2 * SYSTOLIC_UNIT_NUM);
    localparam int unsigned AW     = $clog2(TOKENS * CHUNKS);
    localparam int unsigned IW     = (TOKENS > 1) ? $clog2(TOKENS) : 1;
    localparam int unsigned CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    localparam logic [IW-1:0] LAST_TOK   = IW'(TOKENS - 1);
    localparam logic [CW-1:0] LAST_CHUNK = CW'(CHUNKS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]    state, state_d;
    logic [IW-1:0] q_cnt, q_cnt_d, k_cnt, k_cnt_d;
    logic [CW-1:0] c_cnt, c_cnt_d;
    logic          busy_d, done_d;
    logic [IW-1:0] k_last;
    logic          issue, pair_end, row_end, sweep_end, final_beat;

    logic          s1_valid, s1_pair_last, s1_row_last;
    logic [IW-1:0] s1_q, s1_k;

`ifdef ATTN_FEEDER_CAUSAL_EN
    assign k_last = q_cnt;
`else
    assign k_last = LAST_TOK;
`endif

    assign issue      = (state == RUN) && bus.i_ready;
    assign pair_end   = (c_cnt == LAST_CHUNK);
    assign row_end    = pair_end && (k_cnt == k_last);
    assign sweep_end  = row_end && (q_cnt == LAST_TOK);
    assign final_beat = bus.o_Spikesdata_valid && bus.o_row_last && (bus.o_q_idx == LAST_TOK);

    // Reads go out in the same cycle ready is seen, so the PE sees at most two beats after ready drops.
    assign bus.o_q_rd_en   = issue;
    assign bus.o_k_rd_en   = issue;
    assign bus.o_q_rd_addr = AW'(q_cnt) * AW'(CHUNKS) + AW'(c_cnt);
    assign bus.o_k_rd_addr = AW'(k_cnt) * AW'(CHUNKS) + AW'(c_cnt);

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            state      <= IDLE;
            q_cnt      <= '0;
            k_cnt      <= '0;
            c_cnt      <= '0;
            bus.o_busy <= 1'b0;
            bus.o_done <= 1'b0;
        end else begin
            state      <= state_d;
            q_cnt      <= q_cnt_d;
            k_cnt      <= k_cnt_d;
            c_cnt      <= c_cnt_d;
            bus.o_busy <= busy_d;
            bus.o_done <= done_d;
        end
    end

    // Sweep order: chunk innermost, then key row, then query row.
    always_comb begin
        state_d = state;
        q_cnt_d = q_cnt;
        k_cnt_d = k_cnt;
        c_cnt_d = c_cnt;
        busy_d  = bus.o_busy;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    q_cnt_d = '0;
                    k_cnt_d = '0;
                    c_cnt_d = '0;
                end
            end
            RUN: begin
                if (issue) begin
                    if (!pair_end) begin
                        c_cnt_d = c_cnt + CW'(1);
                    end else begin
                        c_cnt_d = '0;
                        if (!row_end) begin
                            k_cnt_d = k_cnt + IW'(1);
                        end else begin
                            k_cnt_d = '0;
                            if (!sweep_end) begin
                                q_cnt_d = q_cnt + IW'(1);
                            end else begin
                                q_cnt_d = '0;
                                state_d = DRAIN;
                            end
                        end
                    end
                end
            end
            DRAIN: begin
                if (final_beat) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stage 1: tags travel alongside the buffer read latency.
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            s1_valid     <= 1'b0;
            s1_q         <= '0;
            s1_k         <= '0;
            s1_pair_last <= 1'b0;
            s1_row_last  <= 1'b0;
        end else begin
            s1_valid <= issue;
            if (issue) begin
                s1_q         <= q_cnt;
                s1_k         <= k_cnt;
                s1_pair_last <= pair_end;
                s1_row_last  <= row_end;
            end
        end
    end

    // Stage 2: data/index hold between beats; boundary tags only accompany a valid beat.
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            bus.o_Spikesdata_valid <= 1'b0;
            bus.o_SpikesdataQuery  <= '0;
            bus.o_SpikesdataKey    <= '0;
            bus.o_pair_last        <= 1'b0;
            bus.o_row_last         <= 1'b0;
            bus.o_q_idx            <= '0;
            bus.o_k_idx            <= '0;
        end else begin
            bus.o_Spikesdata_valid <= s1_valid;
            bus.o_pair_last        <= s1_valid && s1_pair_last;
            bus.o_row_last         <= s1_valid && s1_row_last;
            if (s1_valid) begin
                bus.o_SpikesdataQuery <= DW'(bus.i_q_rd_data);
                bus.o_SpikesdataKey   <= DW'(bus.i_k_rd_data);
                bus.o_q_idx           <= s1_q;
                bus.o_k_idx           <= s1_k;
            end
        end
    end
endmodule

// File: tb/tb_attn_spike_feeder.sv
// Randomized bench for attn_spike_feeder: beat stream checked against an ordered list of expected beats.
`timescale 1ns/1ps
module tb_attn_spike_feeder;
    localparam int T  = 3;
    localparam int C  = 2;
    localparam int DW = 16;
    localparam int AW = 3;
    localparam int IW = 2;
    localparam int NA = T * C;
`ifdef ATTN_FEEDER_CAUSAL_EN
    localparam int EXP_BEATS = C * T * (T + 1) / 2;
`else
    localparam int EXP_BEATS = C * T * T;
`endif

    typedef struct packed {
        logic [IW-1:0] q;
        logic [IW-1:0] k;
        logic          pl;
        logic          rl;
        logic [DW-1:0] qd;
        logic [DW-1:0] kd;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    attn_spike_feeder_if #(.DW(DW), .AW(AW), .IW(IW)) bus ();

    attn_spike_feeder #(
        .SYSTOLIC_UNIT_NUM(2), .TIME_STEPS(4), .TOKENS(T), .HEAD_DIM(8)
    ) dut (
        .s_clk(clk), .s_rst(rst), .bus(bus)
    );

    logic [DW-1:0] qmem [NA];
    logic [DW-1:0] kmem [NA];

    // Synchronous-read buffers: data one cycle after rd_en.
    always @(posedge clk) begin
        if (bus.o_q_rd_en) bus.i_q_rd_data <= qmem[bus.o_q_rd_addr];
        if (bus.o_k_rd_en) bus.i_k_rd_data <= kmem[bus.o_k_rd_addr];
    end

    int n_checks = 0;
    int n_errors = 0;

    beat_t         exp_q[$];
    beat_t         got_q[$];
    int            got_cyc[$];
    logic [AW-1:0] rdq[$];
    logic [AW-1:0] rdk[$];
    int            rd_cyc[$];
    int            done_cnt;
    int            done_cyc;
    int            stray_tags;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_mems();
        for (int i = 0; i < NA; i++) begin
            qmem[i] = DW'($urandom);
            kmem[i] = DW'($urandom);
        end
    endtask

    // Every (q,k) pair in sweep order, each split into C chunks.
    task automatic build_model();
        beat_t b;
        int kl;
        exp_q.delete();
        for (int q = 0; q < T; q++) begin
`ifdef ATTN_FEEDER_CAUSAL_EN
            kl = q;
`else
            kl = T - 1;
`endif
            for (int k = 0; k <= kl; k++) begin
                for (int c = 0; c < C; c++) begin
                    b.q  = IW'(q);
                    b.k  = IW'(k);
                    b.pl = (c == C - 1);
                    b.rl = (c == C - 1) && (k == kl);
                    b.qd = qmem[q * C + c];
                    b.kd = kmem[k * C + c];
                    exp_q.push_back(b);
                end
            end
        end
    endtask

    task automatic clear_mon();
        got_q.delete(); got_cyc.delete();
        rdq.delete(); rdk.delete(); rd_cyc.delete();
        done_cnt = 0; done_cyc = -1; stray_tags = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        beat_t b;
        @(negedge clk);
        if (bus.o_q_rd_en) begin
            rdq.push_back(bus.o_q_rd_addr);
            rdk.push_back(bus.o_k_rd_addr);
            rd_cyc.push_back(cyc);
        end
        if (bus.o_Spikesdata_valid) begin
            b.q  = bus.o_q_idx;
            b.k  = bus.o_k_idx;
            b.pl = bus.o_pair_last;
            b.rl = bus.o_row_last;
            b.qd = bus.o_SpikesdataQuery;
            b.kd = bus.o_SpikesdataKey;
            got_q.push_back(b);
            got_cyc.push_back(cyc);
        end else if (bus.o_pair_last || bus.o_row_last) begin
            stray_tags++;
        end
        if (bus.o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, 64'({bus.o_Spikesdata_valid, bus.o_q_rd_en, bus.o_k_rd_en,
                                  bus.o_pair_last, bus.o_row_last, bus.o_busy, bus.o_done}), 64'(0));
        check({tag, "_addr"}, 64'({bus.o_q_rd_addr, bus.o_k_rd_addr}), 64'(0));
        check({tag, "_data"}, 64'({bus.o_SpikesdataQuery, bus.o_SpikesdataKey}), 64'(0));
        check({tag, "_idx"}, 64'({bus.o_q_idx, bus.o_k_idx}), 64'(0));
    endtask

    // mode 0: ready high, 1: ready dropped at the 4th read, 2: random ready, 3: extra start mid-run
    task automatic run_test(input int mode);
        int s, drop, busy1, last, win, tail, rd_win, kgtq;
        bit fin;
        logic [11:0] mask;
        fill_mems();
        build_model();
        clear_mon();
        drop = -1; busy1 = 0; fin = 0;
        tick();
        bus.i_ready = 1'b1;
        bus.i_start = 1'b1;
        s = cyc;
        look();
        for (int i = 0; i < 400 && !fin; i++) begin
            tick();
            bus.i_start = 1'b0;
            case (mode)
                1: begin
                    if (drop < 0 && rd_cyc.size() == 3) begin
                        drop = cyc;
                        bus.i_ready = 1'b0;
                    end else begin
                        bus.i_ready = !(drop >= 0 && cyc < drop + 5);
                    end
                end
                2: bus.i_ready = ($urandom_range(3, 0) != 0);
                3: begin
                    bus.i_ready = 1'b1;
                    if (cyc == s + 6) bus.i_start = 1'b1;
                end
                default: bus.i_ready = 1'b1;
            endcase
            look();
            if (cyc == s + 1) busy1 = int'(bus.o_busy);
            if (done_cnt > 0 && cyc >= done_cyc + 3) fin = 1;
        end
        bus.i_ready = 1'b1;

        check($sformatf("m%0d_n_beats", mode), 64'(got_q.size()), 64'(EXP_BEATS));
        check($sformatf("m%0d_n_reads", mode), 64'(rd_cyc.size()), 64'(EXP_BEATS));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("m%0d_beat%0d", mode, i), 64'(got_q[i]), 64'(exp_q[i]));
        check($sformatf("m%0d_n_done", mode), 64'(done_cnt), 64'(1));
        check($sformatf("m%0d_busy_start", mode), 64'(busy1), 64'(1));
        check($sformatf("m%0d_busy_end", mode), 64'(bus.o_busy), 64'(0));
        check($sformatf("m%0d_stray_tags", mode), 64'(stray_tags), 64'(0));
        if (rd_cyc.size() > 0) begin
            check($sformatf("m%0d_first_rd_cyc", mode), 64'(rd_cyc[0] - s), 64'(1));
            check($sformatf("m%0d_first_rd_addr", mode), 64'({rdq[0], rdk[0]}), 64'(0));
        end
        if (got_q.size() > 0) begin
            last = got_q.size() - 1;
            check($sformatf("m%0d_done_lat", mode), 64'(done_cyc - got_cyc[last]), 64'(1));
            if (mode == 0 || mode == 3) begin
                check($sformatf("m%0d_first_valid", mode), 64'(got_cyc[0] - s), 64'(3));
                check($sformatf("m%0d_contig", mode), 64'(got_cyc[last] - got_cyc[0]), 64'(EXP_BEATS - 1));
            end
        end
        if (mode == 0 && got_q.size() >= EXP_BEATS) begin
`ifdef ATTN_FEEDER_CAUSAL_EN
            mask = '0; kgtq = 0;
            for (int i = 0; i < 12; i++) begin
                mask[i] = got_q[i].rl;
                if (got_q[i].k > got_q[i].q) kgtq++;
            end
            check("causal_rl_pos", 64'(mask), 64'(12'h822));
            check("causal_k_le_q", 64'(kgtq), 64'(0));
`else
            mask = '0; kgtq = 0;
            check("b5_tag", 64'({got_q[5].q, got_q[5].k, got_q[5].pl, got_q[5].rl}),
                  64'({2'd0, 2'd2, 1'b1, 1'b1}));
            check("b5_addr", 64'({rdq[5], rdk[5]}), 64'({3'd1, 3'd5}));
            check("b5_data", 64'({got_q[5].qd, got_q[5].kd}), 64'({qmem[1], kmem[5]}));
`endif
        end
        if (mode == 1) begin
            win = 0; tail = 0; rd_win = 0;
            for (int i = 0; i < got_cyc.size(); i++) begin
                if (got_cyc[i] >= drop && got_cyc[i] <= drop + 4) win++;
                if (got_cyc[i] >= drop + 2 && got_cyc[i] <= drop + 6) tail++;
            end
            for (int i = 0; i < rd_cyc.size(); i++)
                if (rd_cyc[i] >= drop && rd_cyc[i] <= drop + 4) rd_win++;
            check("bp_slack_le2", 64'(win <= 2), 64'(1));
            check("bp_quiet", 64'(tail), 64'(0));
            check("bp_no_reads", 64'(rd_win), 64'(0));
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.i_start = 1'b0;
        bus.i_ready = 1'b0;
        fill_mems();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        tick();
        rst = 1'b0;

        run_test(0);
        run_test(1);
        run_test(2);
        run_test(3);

        // Abort mid-run with reset, then restart from scratch.
        fill_mems();
        build_model();
        clear_mon();
        tick();
        bus.i_ready = 1'b1;
        bus.i_start = 1'b1;
        look();
        for (int i = 0; i < 100 && got_q.size() < 8; i++) begin
            tick();
            bus.i_start = 1'b0;
            look();
        end
        check("mid_pre_beats", 64'(got_q.size()), 64'(8));
        tick();
        rst = 1'b1;
        @(negedge clk);
        check_zero("mid_reset");
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            look();
        end
        check("mid_no_done", 64'(done_cnt), 64'(0));
        check("mid_no_beats", 64'(got_q.size()), 64'(8));
        run_test(0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
